fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage directly upstream of the main control decoder. Owns the program counter and drives a req/ack instruction-memory port. Presents one fetched instruction per transfer to decode: o_OPCode feeds the main control i_OPCode, and the full word and PC go to the rest of decode. Handles decode back-pressure through a one-entry skid buffer and handles branch redirects, including squashing an in-flight fetch.

Parameters:
XLEN, 32, width of PC, addresses and instruction word.
RESET_PC, 32'h0000_0000, PC loaded on reset.
NOP_INSTR, 32'h0000_0013, value driven on o_Instr when nothing is valid (addi x0,x0,0).

Ports:
i_clk  in  1  clock; all state updates on the rising edge.
i_rst_n  in  1  reset, synchronous, active-low.
o_IMemReq  out  1  fetch request to instruction memory.
o_IMemAddr  out  XLEN  fetch address; word aligned.
i_IMemAck  in  1  memory response valid; i_IMemData is valid in the same cycle.
i_IMemData  in  XLEN  fetched instruction word.
i_Stall  in  1  decode cannot accept an instruction this cycle.
i_Redirect  in  1  taken branch; restart fetch at i_RedirectPC.
i_RedirectPC  in  XLEN  redirect target; bits [1:0] are ignored and forced to 0.
o_Valid  out  1  o_Instr, o_PC and o_OPCode are valid.
o_Instr  out  XLEN  instruction to decode.
o_PC  out  XLEN  address of o_Instr.
o_OPCode  out  7  o_Instr[6:0]; goes to main control i_OPCode.

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst_n is synchronous and active-low.
- Reset values (i_rst_n=0 at a rising edge): PC=RESET_PC; state=IDLE; o_IMemReq=0; o_IMemAddr=RESET_PC; o_Valid=0; o_Instr=NOP_INSTR; o_PC=RESET_PC; skid buffer empty. Reset overrides all other inputs, including in the middle of a pending fetch.
- Transfer rule: an instruction leaves the stage in any cycle where o_Valid=1 and i_Stall=0.
- Slot free: the output register can accept a new instruction when o_Valid=0, or when a transfer happens in the same cycle.
- Memory protocol: while o_IMemReq=1, o_IMemAddr is held stable until i_IMemAck. i_IMemAck seen while o_IMemReq=0 is ignored.
- Output register: o_Instr is NOP_INSTR whenever o_Valid=0. o_OPCode is always o_Instr[6:0].
- State IDLE: entered only from reset. Next cycle goes to FETCH.
- State FETCH: o_IMemReq=1, o_IMemAddr=PC. On ack:
  - Slot free: load the output register with o_Instr=i_IMemData, o_PC=PC; set o_Valid=1; PC<=PC+4; stay in FETCH and request PC+4 on the next cycle.
  - Slot not free (o_Valid=1 and i_Stall=1): write the data and PC into the skid buffer; PC<=PC+4; go to HOLD.
  - If o_Valid=1, i_Stall=0 and there is no ack: o_Valid<=0.
- State HOLD: o_IMemReq=0. When i_Stall=0, the output transfers, the skid buffer moves into the output register (o_Valid stays 1), and the state returns to FETCH.
- State DROP: o_IMemReq=1, o_IMemAddr stays at the old squashed address. On ack, discard the data and go to FETCH using the redirected PC. o_Valid=0 throughout.
- Redirect (i_Redirect=1): highest priority after reset and wins over i_Stall and i_IMemAck.
  - PC<=i_RedirectPC & ~3; o_Valid<=0; skid buffer cleared.
  - From FETCH with no ack this cycle: go to DROP.
  - From FETCH with ack this cycle, or from HOLD or IDLE: data is discarded; go to FETCH.
  - Redirect while in DROP: update PC and stay in DROP.
- Latency: ack at edge N gives o_Valid=1 after edge N, so zero-wait memory sustains 1 instruction per cycle. First request is issued 1 cycle after reset release.
- PC arithmetic: modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0 with no flag.

Optional Feature:
FETCH_CNT_EN: when defined, adds port o_FetchCnt (out, 32), which counts instructions transferred to decode.
- Resets to 0. Increments by 1 on each transfer; wraps from 32'hFFFF_FFFF to 0.
- Squashed and dropped fetches are not counted.
- Without the macro, the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0; i_rst_n low for 2 cycles, then high -> o_Valid=0, o_Instr=32'h13, o_IMemReq=1 with addr 0 one cycle after release.
- Zero-wait memory returning 32'h00B50533 @0, 32'h00A00093 @4 -> o_Valid=1 on consecutive cycles with o_PC 0 then 4 and o_OPCode 7'b0110011 then 7'b0010011.
- i_Stall=1 while o_Valid=1 and the ack for @8 arrives -> state HOLD, o_IMemReq=0, o_Instr unchanged; drop i_Stall -> @8 word appears next cycle, fetch resumes @C.
- Redirect to 32'h0000_0102 while the @10 fetch is pending (no ack) -> o_Valid=0, addr stays 10 until ack; the ack data is discarded; next request addr=32'h100.
- Redirect to 32'h200 in the same cycle as the ack and i_Stall=1 -> ack data discarded, o_Valid=0, next request addr=32'h200.
- i_rst_n=0 during a pending fetch in DROP -> next cycle state IDLE, o_IMemReq=0, PC=RESET_PC; with FETCH_CNT_EN, o_FetchCnt=0.

Source files
------------

// File: rtl/fetch_stage.sv
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch stage: PC, req/ack imem port, one-entry skid
//            buffer for decode back-pressure, branch redirect with squash.
//            Optional macro FETCH_CNT_EN adds o_FetchCnt transfer counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_IMemReq,
    output logic [XLEN-1:0] o_IMemAddr,
    input  logic            i_IMemAck,
    input  logic [XLEN-1:0] i_IMemData,
    input  logic            i_Stall,
    input  logic            i_Redirect,
    input  logic [XLEN-1:0] i_RedirectPC,
    output logic            o_Valid,
    output logic [XLEN-1:0] o_Instr,
    output logic [XLEN-1:0] o_PC,
    output logic [6:0]      o_OPCode
`ifdef FETCH_CNT_EN
    ,
    output logic [31:0]     o_FetchCnt
`endif
);

    localparam logic [XLEN-1:0] c_PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] c_ALIGN_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t            r_state,      w_next_state;
    logic [XLEN-1:0]   r_pc,         w_next_pc;
    logic              r_valid,      w_next_valid;
    logic [XLEN-1:0]   r_instr,      w_next_instr;
    logic [XLEN-1:0]   r_out_pc,     w_next_out_pc;
    logic [XLEN-1:0]   r_skid_instr, w_next_skid_instr;
    logic [XLEN-1:0]   r_skid_pc,    w_next_skid_pc;
    logic [XLEN-1:0]   r_drop_addr,  w_next_drop_addr;

    logic w_req;
    logic w_ack;
    logic w_transfer;
    logic w_slot_free;

    assign w_req       = (r_state == S_FETCH) || (r_state == S_DROP);
    assign w_ack       = i_IMemAck && w_req;
    assign w_transfer  = r_valid && !i_Stall;
    assign w_slot_free = !r_valid || !i_Stall;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_valid      <= 1'b0;
            r_instr      <= NOP_INSTR;
            r_out_pc     <= RESET_PC;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= RESET_PC;
            r_drop_addr  <= RESET_PC;
        end else begin
            r_state      <= w_next_state;
            r_pc         <= w_next_pc;
            r_valid      <= w_next_valid;
            r_instr      <= w_next_instr;
            r_out_pc     <= w_next_out_pc;
            r_skid_instr <= w_next_skid_instr;
            r_skid_pc    <= w_next_skid_pc;
            r_drop_addr  <= w_next_drop_addr;
        end
    end

    always_comb begin
        w_next_state      = r_state;
        w_next_pc         = r_pc;
        w_next_valid      = r_valid;
        w_next_instr      = r_instr;
        w_next_out_pc     = r_out_pc;
        w_next_skid_instr = r_skid_instr;
        w_next_skid_pc    = r_skid_pc;
        w_next_drop_addr  = r_drop_addr;

        if (i_Redirect) begin
            // Skid contents become dead once we leave HOLD, so no explicit clear.
            w_next_pc    = i_RedirectPC & c_ALIGN_MASK;
            w_next_valid = 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (i_IMemAck) begin
                        w_next_state = S_FETCH;
                    end else begin
                        w_next_state     = S_DROP;
                        w_next_drop_addr = r_pc;
                    end
                end
                S_DROP:  w_next_state = S_DROP;
                default: w_next_state = S_FETCH;
            endcase
        end else begin
            case (r_state)
                S_IDLE: w_next_state = S_FETCH;
                S_FETCH: begin
                    if (w_ack) begin
                        w_next_pc = r_pc + c_PC_STEP;
                        if (w_slot_free) begin
                            w_next_instr  = i_IMemData;
                            w_next_out_pc = r_pc;
                            w_next_valid  = 1'b1;
                        end else begin
                            w_next_skid_instr = i_IMemData;
                            w_next_skid_pc    = r_pc;
                            w_next_state      = S_HOLD;
                        end
                    end else if (w_transfer) begin
                        w_next_valid = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!i_Stall) begin
                        w_next_instr  = r_skid_instr;
                        w_next_out_pc = r_skid_pc;
                        w_next_state  = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (w_ack) begin
                        w_next_state = S_FETCH;
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    // The squashed address must stay on the bus until its ack retires it.
    assign o_IMemReq  = w_req;
    assign o_IMemAddr = (r_state == S_DROP) ? r_drop_addr : r_pc;
    assign o_Valid    = r_valid;
    assign o_Instr    = r_valid ? r_instr : NOP_INSTR;
    assign o_PC       = r_out_pc;
    assign o_OPCode   = o_Instr[6:0];

`ifdef FETCH_CNT_EN
    logic [31:0] r_fetch_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fetch_cnt <= 32'd0;
        end else if (w_transfer) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign o_FetchCnt = r_fetch_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed vector table plus randomized scoreboard for fetch_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [6:0]  opcode;
`ifdef FETCH_CNT_EN
    logic [31:0] fetch_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_IMemReq    (imem_req),
        .o_IMemAddr   (imem_addr),
        .i_IMemAck    (imem_ack),
        .i_IMemData   (imem_data),
        .i_Stall      (stall),
        .i_Redirect   (redirect),
        .i_RedirectPC (redirect_pc),
        .o_Valid      (valid),
        .o_Instr      (instr),
        .o_PC         (pc),
        .o_OPCode     (opcode)
`ifdef FETCH_CNT_EN
        ,
        .o_FetchCnt   (fetch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents as a pure function of address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        ack;
        logic [31:0] data;
        logic        e_req;
        logic        ca;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
    } vec_t;

    function automatic vec_t v(input logic r, input logic s, input logic rd,
                               input logic [31:0] rp, input logic a, input logic [31:0] d,
                               input logic eq, input logic ca, input logic [31:0] ea,
                               input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        vec_t t;
        t.rst_n = r;  t.stall = s;  t.redir = rd; t.rpc = rp; t.ack = a; t.data = d;
        t.e_req = eq; t.ca = ca;    t.e_addr = ea; t.e_valid = ev; t.e_instr = ei; t.e_pc = ep;
        return t;
    endfunction

    vec_t tbl[18];

    initial begin
        int          tb_cnt;
        int          n_xfer;
        logic [31:0] exp_pc;
        logic        prev_hold;
        logic [31:0] prev_addr;

        // rst stall redir rpc ack data | req ca addr valid instr pc
        tbl[0]  = v(1,0,0,0,     0,0,              0,1,32'h000,0,c_NOP,0);
        tbl[1]  = v(1,0,0,0,     1,32'h00B50533,   1,1,32'h000,0,c_NOP,0);
        tbl[2]  = v(1,0,0,0,     1,32'h00A00093,   1,1,32'h004,1,32'h00B50533,32'h0);
        tbl[3]  = v(1,1,0,0,     1,32'h00C00113,   1,1,32'h008,1,32'h00A00093,32'h4);
        tbl[4]  = v(1,1,0,0,     0,0,              0,0,0,      1,32'h00A00093,32'h4);
        tbl[5]  = v(1,0,0,0,     0,0,              0,0,0,      1,32'h00A00093,32'h4);
        tbl[6]  = v(1,0,0,0,     1,32'h00208193,   1,1,32'h00C,1,32'h00C00113,32'h8);
        tbl[7]  = v(1,0,0,0,     0,0,              1,1,32'h010,1,32'h00208193,32'hC);
        tbl[8]  = v(1,0,1,32'h102,0,0,             1,1,32'h010,0,c_NOP,0);
        tbl[9]  = v(1,0,0,0,     0,0,              1,1,32'h010,0,c_NOP,0);
        tbl[10] = v(1,0,0,0,     1,32'hDEADBEEF,   1,1,32'h010,0,c_NOP,0);
        tbl[11] = v(1,0,0,0,     1,32'h00100213,   1,1,32'h100,0,c_NOP,0);
        tbl[12] = v(1,1,1,32'h200,1,32'h11111111,  1,1,32'h104,1,32'h00100213,32'h100);
        tbl[13] = v(1,0,0,0,     0,0,              1,1,32'h200,0,c_NOP,0);
        tbl[14] = v(1,0,1,32'h300,0,0,             1,1,32'h200,0,c_NOP,0);
        tbl[15] = v(0,0,0,0,     0,0,              1,1,32'h200,0,c_NOP,0);
        tbl[16] = v(1,0,0,0,     0,0,              0,1,32'h000,0,c_NOP,0);
        tbl[17] = v(1,0,0,0,     0,0,              1,1,32'h000,0,c_NOP,0);

        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        imem_ack = 1'b0; imem_data = '0;
        repeat (2) @(posedge clk);
        tb_cnt = 0;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst_n = tbl[i].rst_n; stall = tbl[i].stall; redirect = tbl[i].redir;
            redirect_pc = tbl[i].rpc; imem_ack = tbl[i].ack; imem_data = tbl[i].data;
            #1;
            check($sformatf("vec%0d req", i), 32'(imem_req), 32'(tbl[i].e_req));
            if (tbl[i].ca) check($sformatf("vec%0d addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("vec%0d valid", i), 32'(valid), 32'(tbl[i].e_valid));
            check($sformatf("vec%0d instr", i), instr, tbl[i].e_instr);
            check($sformatf("vec%0d opcode", i), 32'(opcode), 32'(tbl[i].e_instr[6:0]));
            if (tbl[i].e_valid) check($sformatf("vec%0d pc", i), pc, tbl[i].e_pc);
`ifdef FETCH_CNT_EN
            check($sformatf("vec%0d cnt", i), fetch_cnt, 32'(tb_cnt));
`endif
            if (!tbl[i].rst_n) tb_cnt = 0;
            else if (tbl[i].e_valid && !tbl[i].stall) tb_cnt++;
        end

        // Randomized run: scoreboard tracks the PC the next transferred
        // instruction must carry, and the memory word that belongs to it.
        exp_pc = 32'h0; tb_cnt = 0; n_xfer = 0; prev_hold = 1'b0; prev_addr = '0;
        for (int i = 0; i < 4000; i++) begin
            logic r_n;
            @(negedge clk);
            r_n = (i < 2) ? 1'b0 : ($urandom_range(999) >= 3);
            rst_n    = r_n;
            stall    = ($urandom_range(99) < 30);
            redirect = ($urandom_range(99) < 5);
            if ($urandom_range(3) == 0) redirect_pc = 32'hFFFF_FFE0 | 32'($urandom_range(31));
            else                        redirect_pc = $urandom;
            if (imem_req) begin
                imem_ack  = ($urandom_range(99) < 60);
                imem_data = mem_word(imem_addr);
            end else begin
                imem_ack  = ($urandom_range(99) < 20);
                imem_data = $urandom;
            end
            #1;
            check("rnd opcode", 32'(opcode), 32'(instr[6:0]));
            if (!valid) check("rnd nop", instr, c_NOP);
            if (imem_req) check("rnd align", 32'(imem_addr[1:0]), 32'd0);
            if (prev_hold) begin
                check("rnd req held", 32'(imem_req), 32'd1);
                check("rnd addr held", imem_addr, prev_addr);
            end
`ifdef FETCH_CNT_EN
            if (i >= 2) check("rnd cnt", fetch_cnt, 32'(tb_cnt));
`endif
            if (r_n) begin
                if (valid && !stall) begin
                    check("rnd xfer pc", pc, exp_pc);
                    check("rnd xfer instr", instr, mem_word(pc));
                    exp_pc = exp_pc + 32'd4;
                    tb_cnt++;
                    n_xfer++;
                end
                if (redirect) exp_pc = redirect_pc & ~32'd3;
            end else begin
                exp_pc = 32'h0;
                tb_cnt = 0;
            end
            prev_hold = r_n && imem_req && !imem_ack;
            prev_addr = imem_addr;
        end

        n_cmp++;
        if (n_xfer < 200) begin
            n_bad++;
            $display("FAIL rnd progress: got %0d transfers, expected at least 200", n_xfer);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
